umac_bi_param: RTL and testbench

Parametrised bipolar unary multiply-accumulate block: N bipolar stochastic input bitstreams, each multiplied by a locally generated weight bitstream, summed by a non-scaled adder into one bipolar output bitstream.
- Generalises the fixed 16-channel, 8-bit MAC to any channel count, weight width and accumulator width.
- Adds an enable, a saturation flag and optional double-buffered weights.
- Sits in the stochastic compute array between the input bitstream generators and the downstream unary accumulator/counter.

---
 rtl/umac_bi_param.sv | 189 ++++++++++++++++++
 tb/tb_umac_bi_param.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/umac_bi_param.sv
// umac_bi_param: N-channel bipolar unary MAC; XNOR multiply, non-scaled add into one bitstream.
// Latency: 1 cycle from iA/weight sample to registered oC/oSat.
// Backpressure: none; en=0 freezes counter, accumulator and outputs, loadB is always accepted.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   en     advance enable for counter, accumulator, oC, oSat
//   iA     N bipolar input bits, one per channel
//   iB     N packed BW-bit offset-binary weights, channel i at iB[i*BW +: BW]
//   loadB  capture iB this cycle
//   oC     registered bipolar output bitstream
//   oSat   registered flag, 1 when the accumulator clipped on the last update
//
// Optional feature: define UMAC_BI_PARAM_SHADOW_EN to double-buffer the weights.
// loadB then writes a shadow bank that is copied to the active bank when the
// sequence counter wraps, so every period uses one consistent weight set.

module umac_bi_param #(
  parameter int N    = 16,
  parameter int BW   = 8,
  parameter int ACCW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    iA,
  input  logic [N*BW-1:0] iB,
  input  logic            loadB,
  output logic            oC,
  output logic            oSat
);

  localparam int CW = $clog2(N + 1);
  // Sum width leaves headroom so acc + d can never overflow before clipping.
  localparam int SW = ACCW + $clog2(N) + 2;

  localparam logic [BW-1:0]        W_ZERO  = BW'(1) << (BW - 1);
  localparam logic signed [SW-1:0] ACC_MAX = SW'((2 ** (ACCW - 1)) - 1);
  localparam logic signed [SW-1:0] ACC_MIN = SW'(-(2 ** (ACCW - 1)));
  localparam logic signed [SW-1:0] D_OFS   = SW'(N - 1);

  // Elaboration-time parameter sanity.
  if (N < 2) begin : g_bad_n
    $error("umac_bi_param: N must be >= 2");
  end
  if (ACCW < CW + 3) begin : g_bad_accw
    $error("umac_bi_param: ACCW must be >= clog2(N+1)+3");
  end

  // ---------------------------------------------------------------------------
  // Sequence source: up-counter, bit-reversed to spread the compare threshold
  // evenly across the period (low-discrepancy van der Corput sequence).
  // ---------------------------------------------------------------------------
  logic [BW-1:0] r_cnt;
  logic [BW-1:0] w_rand;

  for (genvar k = 0; k < BW; k++) begin : g_rev
    assign w_rand[k] = r_cnt[BW-1-k];
  end

  // ---------------------------------------------------------------------------
  // Weight storage
  // ---------------------------------------------------------------------------
  logic [BW-1:0] r_wact [N];

`ifdef UMAC_BI_PARAM_SHADOW_EN
  logic [BW-1:0] r_wsh [N];
  logic          w_wrap;

  // Swap happens on the edge that takes cnt from all-ones back to zero.
  assign w_wrap = en && (r_cnt == '1);

  // The swap reads the shadow value from before this edge, so a loadB on the
  // wrap edge only lands in the shadow bank and waits for the next period.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_wact[i] <= W_ZERO;
        r_wsh[i]  <= W_ZERO;
      end
    end else begin
      if (w_wrap) begin
        for (int i = 0; i < N; i++) begin
          r_wact[i] <= r_wsh[i];
        end
      end
      if (loadB) begin
        for (int i = 0; i < N; i++) begin
          r_wsh[i] <= iB[i*BW +: BW];
        end
      end
    end
  end
`else
  // Direct mode: the compare in the load cycle still sees the old weights.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_wact[i] <= W_ZERO;
      end
    end else if (loadB) begin
      for (int i = 0; i < N; i++) begin
        r_wact[i] <= iB[i*BW +: BW];
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Per-channel weight stream and bipolar multiply
  // ---------------------------------------------------------------------------
  logic [N-1:0] w_wbit;
  logic [N-1:0] w_p;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign w_wbit[i] = (r_wact[i] > w_rand);
  end

  // Bipolar product is XNOR: equal signs give +1.
  assign w_p = ~(iA ^ w_wbit);

  // ---------------------------------------------------------------------------
  // Popcount of products
  // ---------------------------------------------------------------------------
  logic [CW-1:0] w_ones;

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < N; i++) begin
      w_ones = w_ones + CW'(w_p[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Non-scaled adder
  //   d        = 2*ones - (N-1)
  //   sum      = acc + d
  //   out      = sum > 0
  //   acc_next = clip(sum - 2*out)
  // The -(N-1) offset together with the -2*out feedback equals the true
  // bipolar residue acc + sum(2p-1) - (2out-1).
  // ---------------------------------------------------------------------------
  logic signed [ACCW-1:0] r_acc;
  logic signed [SW-1:0]   w_acc_ext;
  logic signed [SW-1:0]   w_d;
  logic signed [SW-1:0]   w_sum;
  logic signed [SW-1:0]   w_pre;
  logic                   w_out;
  logic signed [ACCW-1:0] w_acc_next;
  logic                   w_clip;

  assign w_acc_ext = {{(SW-ACCW){r_acc[ACCW-1]}}, r_acc};
  assign w_d       = $signed({{(SW-CW-1){1'b0}}, w_ones, 1'b0}) - D_OFS;
  assign w_sum     = w_acc_ext + w_d;
  // Strictly positive: sign bit clear and not zero.
  assign w_out     = ~w_sum[SW-1] & (|w_sum);
  assign w_pre     = w_sum - $signed({{(SW-2){1'b0}}, w_out, 1'b0});

  always_comb begin
    w_acc_next = w_pre[ACCW-1:0];
    w_clip     = 1'b0;
    if (w_pre > ACC_MAX) begin
      w_acc_next = ACC_MAX[ACCW-1:0];
      w_clip     = 1'b1;
    end else if (w_pre < ACC_MIN) begin
      w_acc_next = ACC_MIN[ACCW-1:0];
      w_clip     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
      oC    <= 1'b0;
      oSat  <= 1'b0;
    end else if (en) begin
      r_cnt <= r_cnt + BW'(1);
      r_acc <= w_acc_next;
      oC    <= w_out;
      oSat  <= w_clip;
    end
  end

endmodule

// File: tb/tb_umac_bi_param.sv
// Bench for umac_bi_param: behavioural model plus directed and random phases.
// Latency: model and DUT both advance on each rising edge.
// Backpressure: not applicable.

module tb_umac_bi_param;

  localparam int N    = 16;
  localparam int BW   = 8;
  localparam int ACCW = 8;
  localparam int PER  = 1 << BW;
  localparam int AMAX = (1 << (ACCW - 1)) - 1;
  localparam int AMIN = -(1 << (ACCW - 1));

  logic            clk;
  logic            rst;
  logic            en;
  logic [N-1:0]    iA;
  logic [N*BW-1:0] iB;
  logic            loadB;
  logic            oC;
  logic            oSat;

  umac_bi_param #(.N(N), .BW(BW), .ACCW(ACCW)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .iA    (iA),
    .iB    (iB),
    .loadB (loadB),
    .oC    (oC),
    .oSat  (oSat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model: integer arithmetic straight from the block's rules.
  // ---------------------------------------------------------------------------
  int m_cnt, m_acc;
  bit m_oc, m_sat;
  int m_w   [N];
  int m_wsh [N];
  int md_rnd, md_ones, md_sum, md_nx;
  bit md_o;

  initial begin
    m_cnt = 0; m_acc = 0; m_oc = 0; m_sat = 0;
    for (int i = 0; i < N; i++) begin
      m_w[i] = PER / 2;
      m_wsh[i] = PER / 2;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_acc = 0; m_oc = 0; m_sat = 0;
      for (int i = 0; i < N; i++) begin
        m_w[i] = PER / 2;
        m_wsh[i] = PER / 2;
      end
    end else begin
      if (en) begin
        md_rnd = 0;
        for (int k = 0; k < BW; k++)
          if (((m_cnt >> k) & 1) == 1) md_rnd = md_rnd | (1 << (BW - 1 - k));
        md_ones = 0;
        for (int i = 0; i < N; i++)
          if (iA[i] == (m_w[i] > md_rnd)) md_ones++;
        md_sum = m_acc + 2 * md_ones - (N - 1);
        md_o   = (md_sum > 0);
        md_nx  = md_sum - (md_o ? 2 : 0);
        m_sat  = (md_nx > AMAX) || (md_nx < AMIN);
        if (md_nx > AMAX) md_nx = AMAX;
        if (md_nx < AMIN) md_nx = AMIN;
        m_acc = md_nx;
        m_oc  = md_o;
`ifdef UMAC_BI_PARAM_SHADOW_EN
        if (m_cnt == PER - 1)
          for (int i = 0; i < N; i++) m_w[i] = m_wsh[i];
`endif
        m_cnt = (m_cnt + 1) % PER;
      end
      if (loadB) begin
        for (int i = 0; i < N; i++) begin
`ifdef UMAC_BI_PARAM_SHADOW_EN
          m_wsh[i] = int'(iB[i*BW +: BW]);
`else
          m_w[i] = int'(iB[i*BW +: BW]);
`endif
        end
      end
    end
  end

  // Single compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    checks++;
    if (oC !== m_oc || oSat !== m_sat) begin
      errors++;
      $display("FAIL model_cmp t=%0t: oC=%b oSat=%b, model oC=%b oSat=%b",
               $time, oC, oSat, m_oc, m_sat);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  function automatic logic [N*BW-1:0] allw(input int v);
    logic [N*BW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = BW'(v);
    return r;
  endfunction

  function automatic logic [N*BW-1:0] rndw();
    logic [N*BW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = BW'($urandom_range(PER - 1));
    return r;
  endfunction

  // Drive one cycle of inputs, wait for the edge, sample 1 time unit later.
  task automatic cyc(input bit e, input logic [N-1:0] a, input bit lb,
                     input logic [N*BW-1:0] b);
    en = e; iA = a; loadB = lb; iB = b;
    @(posedge clk);
    #1;
  endtask

  int  ones_cnt, sat_cnt, guard, first;
  bit  found, h_oc, h_sat;
  logic [N-1:0] all1;

  initial begin
    all1  = '1;
    rst   = 1'b1;
    en    = 1'b0;
    iA    = '0;
    loadB = 1'b0;
    iB    = '0;

    // Reset with random activity, including loads that must be ignored.
    for (int c = 0; c < 2; c++) begin
      cyc(1'($urandom_range(1)), N'($urandom()), 1'b1, rndw());
      chk("rst_oC", int'(oC), 0);
      chk("rst_oSat", int'(oSat), 0);
    end
    rst = 1'b0;

    // After reset, iA=0 with bipolar-zero weights: half ones.
    ones_cnt = 0;
    for (int c = 0; c < PER; c++) begin
      cyc(1'b1, '0, 1'b0, '0);
      if (c == 0) chk("rel_first_oC", int'(oC), 0);
      if (c == 1) chk("rel_second_oC", int'(oC), 1);
      ones_cnt += int'(oC);
    end
    chk_rng("rel_ones", ones_cnt, PER/2 - 2, PER/2 + 2);

    // Zero weights, iA all ones: ones alternates 16/0.
    ones_cnt = 0; sat_cnt = 0;
    for (int c = 0; c < 2 * PER; c++) begin
      cyc(1'b1, all1, 1'b0, '0);
      if (c == 0) chk("zero_first_oC", int'(oC), 1);
      if (c >= PER) ones_cnt += int'(oC);
      sat_cnt += int'(oSat);
    end
    chk_rng("zero_ones", ones_cnt, PER/2 - 1, PER/2 + 1);
    chk("zero_sat", sat_cnt, 0);

    // Positive saturation.
    cyc(1'b0, all1, 1'b1, allw(PER - 1));
    found = 0;
    for (int c = 0; c < 12 && !found; c++) begin
      cyc(1'b1, all1, 1'b0, '0);
      if (oSat) found = 1;
    end
    chk("pos_sat_reach", int'(found), 1);
    ones_cnt = 0; sat_cnt = 0;
    for (int c = 0; c < PER; c++) begin
      cyc(1'b1, all1, 1'b0, '0);
      ones_cnt += int'(oC);
      sat_cnt  += int'(oSat);
    end
    chk_rng("pos_ones", ones_cnt, PER - 1, PER);
    chk_rng("pos_sat", sat_cnt, PER - 6, PER);

    // Negative saturation.
    cyc(1'b0, all1, 1'b1, allw(0));
    for (int c = 0; c < 30; c++) cyc(1'b1, all1, 1'b0, '0);
    ones_cnt = 0; sat_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      cyc(1'b1, all1, 1'b0, '0);
      ones_cnt += int'(oC);
      sat_cnt  += int'(oSat);
    end
    chk("neg_ones", ones_cnt, 0);
    chk("neg_sat", sat_cnt, 100);

    // Enable hold mid-stream with random inputs and a weight load.
    cyc(1'b0, '0, 1'b1, rndw());
    for (int c = 0; c < 50; c++) cyc(1'b1, N'($urandom()), 1'b0, '0);
    h_oc = m_oc; h_sat = m_sat;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0, N'($urandom()), 1'($urandom_range(1)), rndw());
      chk("hold_oC", int'(oC), int'(h_oc));
      chk("hold_oSat", int'(oSat), int'(h_sat));
    end
    for (int c = 0; c < 100; c++) cyc(1'b1, N'($urandom()), 1'b0, '0);

    // Weight load at cnt=100 from saturated-positive weights.
    cyc(1'b0, all1, 1'b1, allw(PER - 1));
    for (int c = 0; c < PER + 20; c++) cyc(1'b1, all1, 1'b0, '0);
    guard = 0;
    while (m_cnt != 100 && guard < 2 * PER) begin
      cyc(1'b1, all1, 1'b0, '0);
      guard++;
    end
    chk("load_reach_cnt", int'(m_cnt == 100), 1);
    cyc(1'b1, all1, 1'b1, allw(0));
`ifdef UMAC_BI_PARAM_SHADOW_EN
    ones_cnt = 0; guard = 0;
    while (m_cnt != 0 && guard < PER) begin
      cyc(1'b1, all1, 1'b0, '0);
      ones_cnt += int'(oC);
      guard++;
    end
    chk("shadow_hold_ones", ones_cnt, PER - 101);
`endif
    first = -1;
    for (int c = 0; c < 20 && first < 0; c++) begin
      cyc(1'b1, all1, 1'b0, '0);
      if (!oC) first = c;
    end
    chk_rng("load_fall", first, 0, 12);
    ones_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      cyc(1'b1, all1, 1'b0, '0);
      ones_cnt += int'(oC);
    end
    chk("load_stays_low", ones_cnt, 0);

    // Random phase: model compare runs every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      cyc(($urandom_range(3) != 0), N'($urandom()), ($urandom_range(9) == 0), rndw());
    end
    rst = 1'b0;
    cyc(1'b0, '0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
